spi_ram_target: RTL and testbench
=================================

# spi_ram_target

SPI slave that emulates a 23LC-style serial SRAM (sequential mode), the responder for our SPI RAM controller. It sits on the FPGA side of the SPI bus and lets the controller and its demo top be exercised board-to-board or in simulation without a physical RAM chip. The SPI pins are oversampled on the system clock, and the block decodes READ (0x03) and WRITE (0x02) with a 16-bit address. Data is held in an internal byte array.

## Interface
Parameters:
- DEPTH_LOG2, 8: memory holds 2^DEPTH_LOG2 bytes; only address bits [DEPTH_LOG2-1:0] are used, upper bits are ignored.

Ports:
- clk  in  1  system clock; all logic runs on it.
- rst  in  1  reset; asynchronous, active-high.
- spi_select  in  1  chip select, active low.
- spi_clk_in  in  1  SCK from the initiator, SPI mode 0.
- spi_mosi  in  1  serial data from the initiator.
- spi_miso  out  1  serial data to the initiator.
- spi_miso_oe  out  1  output enable for the MISO pad; high only during the READ data phase.
- selected  out  1  synchronized, inverted spi_select.
- byte_done  out  1  one-clk pulse after each complete data byte is read or written.
- cur_addr  out  16  current transaction address; advances after each data byte.

## Operation
- Input conditioning:
  - spi_clk_in, spi_select and spi_mosi each pass through a 2-flop synchronizer.
  - SCK gets a third flop for edge detection, giving sck_rise and sck_fall one-clk pulses.
  - The mosi sample used at sck_rise is taken from the same pipeline stage as the detected edge.
- States: IDLE, CMD, ADDR, READ_DATA, WRITE_DATA, IGNORE.
- IDLE:
  - Selection goes active → CMD.
  - bit_cnt, rx_sr and cur_addr are cleared.
- Shifting: on each sck_rise, rx_sr <= {rx_sr[6:0], mosi} and bit_cnt increments modulo 8. A byte completes on the 8th rise.
- CMD, on byte completion:
  - 0x03 → ADDR, then READ_DATA.
  - 0x02 → ADDR, then WRITE_DATA.
  - Any other value → IGNORE.
- ADDR:
  - Two bytes are received MSB first into cur_addr, high byte then low byte.
  - On completion of the second byte the state moves to READ_DATA or WRITE_DATA according to the latched command.
- WRITE_DATA:
  - On each byte completion: mem[cur_addr] <= {rx_sr[6:0], mosi}, cur_addr <= cur_addr+1, byte_done pulses.
- READ_DATA, on each sck_fall:
  - If bit_cnt==0: spi_miso <= mem[cur_addr][7], tx_sr <= mem[cur_addr][6:0], cur_addr <= cur_addr+1, byte_done pulses.
  - Otherwise: spi_miso <= tx_sr MSB and tx_sr shifts left.
  - The first data bit is therefore driven on the falling edge that follows the 24th rising edge.
- IGNORE: spi_miso held 0 and oe held 0; no memory access until deselect.
- Address arithmetic:
  - cur_addr is 16 bits and wraps 0xFFFF→0x0000.
  - Memory indexing uses the low DEPTH_LOG2 bits, so sequential access wraps at the array boundary.
- Deselect at any time:
  - Next clk → IDLE; spi_miso_oe and spi_miso go to 0.
  - A partially received write byte is discarded; completed bytes remain written.
- Reset:
  - All outputs go to 0; state goes to IDLE; shift registers and counters clear.
  - Memory contents are not reset (undefined after power-up).
  - Reset mid-transaction aborts the transaction. The block does not respond again until a fresh select falling edge, i.e. selected must be seen low before CMD is entered.

## Timing
- Pin-to-detect latency is 3 clk for sck_rise/sck_fall; spi_miso is registered, so a MISO change lands 4 clk after the SCK falling edge at the pin.
- Requirement: SCK high and low times ≥ 6 clk each (SCK ≤ clk/12). Setup from spi_select low to first SCK rise ≥ 4 clk.
- Write latency: memory is updated, and byte_done pulses, 4 clk after the 8th SCK rise at the pin.
- byte_done is exactly one clk wide. Simultaneous deselect and byte completion on the same clk: deselect wins, no write occurs.
- Memory is a synchronous-write, asynchronous-read array (maps to distributed RAM).

## Structure
- Package spi_ram_pkg:
  - CMD_READ = 8'h03, CMD_WRITE = 8'h02.
  - The state enum.
  - ADDR_BYTES = 2.
- One sub-module, spi_in_sync: parameterized-depth synchronizer with optional rise/fall pulse outputs. Instantiated for SCK (with edges), select and mosi.

## Test plan
- Write 0x02, 0x0010, data DE AD BE EF; then read 0x03, 0x0010, 4 bytes → MISO returns DE AD BE EF; cur_addr ends at 0x0014; four byte_done pulses in each transaction.
- Write at 0x00FF with DEPTH_LOG2=8, data 11 22 → mem[0xFF]=0x11, mem[0x00]=0x22; read from 0x00FF returns 11 22.
- Deselect after 3 bits of the second data byte in a write of AA 55 at 0x0020 → mem[0x20]=0xAA, mem[0x21] unchanged; state returns to IDLE; oe stays 0.
- Command 0x05 followed by 24 SCK cycles → spi_miso_oe and spi_miso stay 0; no memory location changes; no byte_done.
- Assert rst during a READ address phase, release, select anew and issue a read of 0x0010 → correct data; outputs are 0 throughout reset.
- Run the SPI RAM controller at clk/12 against the block → controller writes and read-backs of 32-bit words match.

Source files
------------

// File: rtl/spi_ram_pkg.sv
// Shared command codes, address framing and FSM states for the SPI RAM target.
package spi_ram_pkg;

    localparam logic [7:0] CMD_READ   = 8'h03;
    localparam logic [7:0] CMD_WRITE  = 8'h02;
    localparam int         ADDR_BYTES = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_READ_DATA,
        ST_WRITE_DATA,
        ST_IGNORE
    } spi_state_e;

endpackage

// File: rtl/spi_in_sync.sv
// Multi-flop input synchronizer with optional registered rise/fall pulses
// taken from one extra flop behind the synchronized output.
module spi_in_sync #(
    parameter int   DEPTH   = 2,
    parameter bit   EDGES   = 1'b0,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [DEPTH-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {DEPTH{RST_VAL}};
        end else begin
            sync_q <= {sync_q[DEPTH-2:0], d_i};
        end
    end

    assign q_o = sync_q[DEPTH-1];

    generate
        if (EDGES) begin : g_edges
            logic last_q;
            logic rise_q;
            logic fall_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    last_q <= RST_VAL;
                    rise_q <= 1'b0;
                    fall_q <= 1'b0;
                end else begin
                    last_q <= sync_q[DEPTH-1];
                    rise_q <= sync_q[DEPTH-1] & ~last_q;
                    fall_q <= ~sync_q[DEPTH-1] & last_q;
                end
            end

            assign rise_o = rise_q;
            assign fall_o = fall_q;
        end else begin : g_no_edges
            assign rise_o = 1'b0;
            assign fall_o = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/spi_ram_target.sv
// SPI mode-0 slave emulating a 23LC-style serial SRAM in sequential mode
// (READ 0x03 / WRITE 0x02, 16-bit address), with pins oversampled on clk.
//
// state         | meaning
// ST_IDLE       | deselected; counters and address cleared
// ST_CMD        | receiving the command byte
// ST_ADDR       | receiving address bytes, high byte first
// ST_READ_DATA  | shifting memory bytes out on MISO at SCK falls
// ST_WRITE_DATA | storing each completed MOSI byte
// ST_IGNORE     | unknown command; silent until deselect
module spi_ram_target
    import spi_ram_pkg::*;
#(
    parameter int DEPTH_LOG2 = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spi_select,
    input  logic        spi_clk_in,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        spi_miso_oe,
    output logic        selected,
    output logic        byte_done,
    output logic [15:0] cur_addr
);

    logic sel_n_s, sck_s, mosi_s;
    logic sck_rise, sck_fall;
    logic sel_rise, sel_fall, mosi_rise, mosi_fall;
    logic unused_sync;

    spi_in_sync #(.DEPTH(2), .EDGES(1'b1), .RST_VAL(1'b0)) u_sck_sync (
        .clk(clk), .rst(rst), .d_i(spi_clk_in),
        .q_o(sck_s), .rise_o(sck_rise), .fall_o(sck_fall)
    );

    // Select resets to "asserted" so a reset cannot arm the FSM until the pin is seen high.
    spi_in_sync #(.DEPTH(2), .EDGES(1'b0), .RST_VAL(1'b0)) u_sel_sync (
        .clk(clk), .rst(rst), .d_i(spi_select),
        .q_o(sel_n_s), .rise_o(sel_rise), .fall_o(sel_fall)
    );

    // One stage deeper than select so the sample lines up with the registered SCK edge.
    spi_in_sync #(.DEPTH(3), .EDGES(1'b0), .RST_VAL(1'b0)) u_mosi_sync (
        .clk(clk), .rst(rst), .d_i(spi_mosi),
        .q_o(mosi_s), .rise_o(mosi_rise), .fall_o(mosi_fall)
    );

    assign unused_sync = ^{sck_s, sel_rise, sel_fall, mosi_rise, mosi_fall};

    spi_state_e  state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  rx_sr_q, rx_sr_d;
    logic [6:0]  tx_sr_q, tx_sr_d;
    logic [15:0] cur_addr_q, cur_addr_d;
    logic [1:0]  addr_cnt_q, addr_cnt_d;
    logic        is_read_q, is_read_d;
    logic        miso_q, miso_d;
    logic        oe_q, oe_d;
    logic        done_q, done_d;
    logic        sel_q, sel_d;
    logic        armed_q, armed_d;

    logic [7:0]  mem [2**DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] mem_idx;
    logic [7:0]  mem_rd;
    logic [7:0]  rx_full;
    logic        sel_act;
    logic        byte_end;
    logic        mem_we;

    assign sel_act  = ~sel_n_s;
    assign mem_idx  = cur_addr_q[DEPTH_LOG2-1:0];
    assign mem_rd   = mem[mem_idx];
    assign rx_full  = {rx_sr_q[6:0], mosi_s};
    assign byte_end = sck_rise && (bit_cnt_q == 3'd7);

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_sr_d    = rx_sr_q;
        tx_sr_d    = tx_sr_q;
        cur_addr_d = cur_addr_q;
        addr_cnt_d = addr_cnt_q;
        is_read_d  = is_read_q;
        miso_d     = miso_q;
        done_d     = 1'b0;
        mem_we     = 1'b0;
        sel_d      = sel_act;
        armed_d    = armed_q | ~sel_act;

        if (sck_rise) begin
            rx_sr_d   = rx_full;
            bit_cnt_d = bit_cnt_q + 3'd1;
        end

        case (state_q)
            ST_IDLE: begin
                bit_cnt_d  = 3'd0;
                rx_sr_d    = 8'h00;
                cur_addr_d = 16'h0000;
                addr_cnt_d = 2'd0;
                miso_d     = 1'b0;
                if (sel_act && armed_q) begin
                    state_d = ST_CMD;
                end
            end
            ST_CMD: begin
                if (byte_end) begin
                    if (rx_full == CMD_READ) begin
                        is_read_d = 1'b1;
                        state_d   = ST_ADDR;
                    end else if (rx_full == CMD_WRITE) begin
                        is_read_d = 1'b0;
                        state_d   = ST_ADDR;
                    end else begin
                        state_d   = ST_IGNORE;
                    end
                end
            end
            ST_ADDR: begin
                if (byte_end) begin
                    cur_addr_d = {cur_addr_q[7:0], rx_full};
                    if (addr_cnt_q == 2'(ADDR_BYTES - 1)) begin
                        addr_cnt_d = 2'd0;
                        state_d    = is_read_q ? ST_READ_DATA : ST_WRITE_DATA;
                    end else begin
                        addr_cnt_d = addr_cnt_q + 2'd1;
                    end
                end
            end
            ST_WRITE_DATA: begin
                if (byte_end) begin
                    mem_we     = 1'b1;
                    cur_addr_d = cur_addr_q + 16'd1;
                    done_d     = 1'b1;
                end
            end
            ST_READ_DATA: begin
                if (sck_fall) begin
                    if (bit_cnt_q == 3'd0) begin
                        miso_d     = mem_rd[7];
                        tx_sr_d    = mem_rd[6:0];
                        cur_addr_d = cur_addr_q + 16'd1;
                        done_d     = 1'b1;
                    end else begin
                        miso_d  = tx_sr_q[6];
                        tx_sr_d = {tx_sr_q[5:0], 1'b0};
                    end
                end
            end
            ST_IGNORE: begin
                miso_d = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Deselect overrides everything, including a byte completing on this clk.
        if (!sel_act) begin
            state_d = ST_IDLE;
            miso_d  = 1'b0;
            done_d  = 1'b0;
            mem_we  = 1'b0;
        end

        oe_d = (state_d == ST_READ_DATA);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 3'd0;
            rx_sr_q    <= 8'h00;
            tx_sr_q    <= 7'h00;
            cur_addr_q <= 16'h0000;
            addr_cnt_q <= 2'd0;
            is_read_q  <= 1'b0;
            miso_q     <= 1'b0;
            oe_q       <= 1'b0;
            done_q     <= 1'b0;
            sel_q      <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_sr_q    <= rx_sr_d;
            tx_sr_q    <= tx_sr_d;
            cur_addr_q <= cur_addr_d;
            addr_cnt_q <= addr_cnt_d;
            is_read_q  <= is_read_d;
            miso_q     <= miso_d;
            oe_q       <= oe_d;
            done_q     <= done_d;
            sel_q      <= sel_d;
            armed_q    <= armed_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_idx] <= rx_full;
        end
    end

    assign spi_miso    = miso_q;
    assign spi_miso_oe = oe_q;
    assign selected    = sel_q;
    assign byte_done   = done_q;
    assign cur_addr    = cur_addr_q;

endmodule

// File: tb/tb_spi_ram_target.sv
// Randomized bench for spi_ram_target: a bit-banged SPI initiator against a
// plain byte-array model of the 256-byte RAM.
module tb_spi_ram_target;

    localparam int HALF = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        spi_select = 1'b1;
    logic        spi_clk_in = 1'b0;
    logic        spi_mosi = 1'b0;
    logic        spi_miso, spi_miso_oe, selected, byte_done;
    logic [15:0] cur_addr;

    spi_ram_target #(.DEPTH_LOG2(8)) dut (
        .clk(clk), .rst(rst), .spi_select(spi_select), .spi_clk_in(spi_clk_in),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .selected(selected), .byte_done(byte_done), .cur_addr(cur_addr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    int   bd_cnt = 0, oe_cnt = 0, miso_hi_cnt = 0, bd_wide = 0;
    logic bd_prev = 1'b0;
    always @(negedge clk) begin
        if (byte_done) bd_cnt++;
        if (byte_done && bd_prev) bd_wide++;
        bd_prev = byte_done;
        if (spi_miso_oe) oe_cnt++;
        if (spi_miso) miso_hi_cnt++;
    end

    logic [7:0] ref_mem [256];
    logic [7:0] txb [$];
    logic [7:0] rxb [$];

    // One SCK period: MOSI set while low, MISO sampled just before the rise.
    task automatic sck_bit(input logic b, input bit hold_high, output logic m);
        spi_mosi = b;
        repeat (HALF) @(negedge clk);
        m = spi_miso;
        spi_clk_in = 1'b1;
        repeat (HALF) @(negedge clk);
        if (!hold_high) spi_clk_in = 1'b0;
    endtask

    // Frames end with SCK still high so no trailing fall reaches the target.
    task automatic xfer(input int nbits, output logic [15:0] addr_end);
        logic       m;
        logic [7:0] acc, cb;
        acc = 8'h00;
        rxb.delete();
        spi_select = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            cb = txb[i/8];
            sck_bit(cb[7-(i%8)], i == nbits - 1, m);
            acc = {acc[6:0], m};
            if (i % 8 == 7) rxb.push_back(acc);
        end
        addr_end = cur_addr;
        spi_select = 1'b1;
        repeat (3) @(negedge clk);
        spi_clk_in = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic frame(input logic [7:0] cmd, input logic [15:0] addr);
        txb.delete();
        txb.push_back(cmd);
        txb.push_back(addr[15:8]);
        txb.push_back(addr[7:0]);
    endtask

    task automatic do_write(input logic [15:0] addr, input logic [7:0] dq [$], input int cut);
        int nbits, nfull, bd0, oe0;
        logic [15:0] ae, exp_a;
        frame(8'h02, addr);
        foreach (dq[k]) txb.push_back(dq[k]);
        nbits = 8 * dq.size() - cut;
        nfull = nbits / 8;
        bd0 = bd_cnt; oe0 = oe_cnt;
        xfer(24 + nbits, ae);
        for (int k = 0; k < nfull; k++) ref_mem[8'(addr + 16'(k))] = dq[k];
        exp_a = addr + 16'(nfull);
        chk("wr_byte_done", bd_cnt - bd0, nfull);
        chk("wr_cur_addr", {16'h0, ae}, {16'h0, exp_a});
        chk("wr_oe_low", oe_cnt - oe0, 0);
    endtask

    task automatic do_read(input logic [15:0] addr, input int n);
        int bd0, oe0;
        logic [15:0] ae, exp_a;
        frame(8'h03, addr);
        for (int k = 0; k < n; k++) txb.push_back(8'($urandom));
        bd0 = bd_cnt; oe0 = oe_cnt;
        xfer(24 + 8 * n, ae);
        exp_a = addr + 16'(n);
        chk("rd_hdr_miso", {8'h0, rxb[0], rxb[1], rxb[2]}, 0);
        for (int k = 0; k < n; k++)
            chk($sformatf("rd_data[%0h]", 16'(addr + 16'(k))), {24'h0, rxb[3+k]},
                {24'h0, ref_mem[8'(addr + 16'(k))]});
        chk("rd_byte_done", bd_cnt - bd0, n);
        chk("rd_cur_addr", {16'h0, ae}, {16'h0, exp_a});
        chk("rd_oe_seen", (oe_cnt - oe0) > 0, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0]  dq [$];
        logic [15:0] ae, a;
        logic        m;
        int          bd0, oe0, mh0, n, cut;

        repeat (3) @(negedge clk);
        chk("reset_outputs", {12'h0, spi_miso, spi_miso_oe, selected, byte_done, cur_addr}, 0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("idle_selected", {31'h0, selected}, 0);

        // Fill the whole array so every later read has a known expectation.
        dq.delete();
        for (int k = 0; k < 256; k++) dq.push_back(8'($urandom));
        do_write(16'h0000, dq, 0);

        dq = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        do_write(16'h0010, dq, 0);
        do_read(16'h0010, 4);

        dq = '{8'h11, 8'h22};
        do_write(16'h00FF, dq, 0);
        do_read(16'h00FF, 2);

        dq = '{8'h5A, 8'hC3};
        do_write(16'hFFFF, dq, 0);
        do_read(16'hFFFF, 2);

        dq = '{8'hAA, 8'h55};
        do_write(16'h0020, dq, 5);
        chk("desel_selected", {31'h0, selected}, 0);
        chk("desel_addr_clr", {16'h0, cur_addr}, 0);
        do_read(16'h0020, 2);

        // Unknown command followed by what looks like a write header.
        txb = '{8'h05, 8'h02, 8'h00, 8'h30};
        bd0 = bd_cnt; oe0 = oe_cnt; mh0 = miso_hi_cnt;
        xfer(32, ae);
        chk("ign_byte_done", bd_cnt - bd0, 0);
        chk("ign_oe", oe_cnt - oe0, 0);
        chk("ign_miso", miso_hi_cnt - mh0, 0);
        do_read(16'h0030, 4);

        // Reset in the middle of a read address phase.
        frame(8'h03, 16'h0010);
        txb.push_back(8'hFF); txb.push_back(8'hFF);
        spi_select = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < 12; i++) sck_bit(txb[i/8][7-(i%8)], 1'b0, m);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("midrst_outputs", {12'h0, spi_miso, spi_miso_oe, selected, byte_done, cur_addr}, 0);
        end
        rst = 1'b0;
        bd0 = bd_cnt; oe0 = oe_cnt;
        for (int i = 12; i < 40; i++) sck_bit(txb[i/8][7-(i%8)], 1'b0, m);
        chk("postrst_no_done", bd_cnt - bd0, 0);
        chk("postrst_no_oe", oe_cnt - oe0, 0);
        spi_select = 1'b1;
        repeat (8) @(negedge clk);
        do_read(16'h0010, 4);

        for (int t = 0; t < 8; t++) begin
            a   = 16'($urandom);
            n   = $urandom_range(1, 6);
            cut = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
            dq.delete();
            for (int k = 0; k < n; k++) dq.push_back(8'($urandom));
            do_write(a, dq, cut);
            do_read(($urandom_range(0, 1) == 0) ? a : 16'($urandom), $urandom_range(1, 8));
        end

        chk("byte_done_width", bd_wide, 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
